// File: rtl/alu.sv
// alu: registered 32-bit execute-stage ALU; nine operations, undefined opcodes yield zero.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_out
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] data_d, data_q;
  logic [SW-1:0]    sh;
  logic             big_shift;
  assign sh        = data_b[SW-1:0];
  // The whole of data_b counts as the shift amount, so any upper bit saturates the shift.
  assign big_shift = |data_b[WIDTH-1:SW];
  always_comb begin
    data_d = '0;
    case (opcode)
      5'd0: data_d = data_a + data_b;
      5'd1: data_d = data_a - data_b;
      5'd2: data_d = data_a * data_b;
      5'd3: data_d = data_a & data_b;
      5'd4: data_d = data_a | data_b;
      5'd5: data_d = data_a ^ data_b;
      5'd6: data_d = big_shift ? '0 : data_a << sh;
      5'd7: data_d = big_shift ? {WIDTH{data_a[WIDTH-1]}} : WIDTH'($signed(data_a) >>> sh);
      5'd8: data_d = big_shift ? '0 : data_a >> sh;
      default: data_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end
  assign data_out = data_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table, reset/latency sequences and randomized checks against an arithmetic model.
module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] data_a = 32'd0;
  logic [31:0] data_b = 32'd0;
  logic [31:0] data_out;
  int total = 0;
  int bad = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .data_a(data_a), .data_b(data_b), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, p, q;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    p = 1;
    if (b < 32) for (int i = 0; i < int'(b); i++) p = p * 2;
    case (op)
      5'd0: return 32'(ua + ub);
      5'd1: return 32'(ua - ub);
      5'd2: return 32'(ua * ub);
      5'd3: return a & b;
      5'd4: return a | b;
      5'd5: return a ^ b;
      5'd6: return (b >= 32) ? 32'd0 : 32'(ua * p);
      5'd7: begin
        if (b >= 32) return (sa < 0) ? 32'hFFFF_FFFF : 32'd0;
        q = sa / p;
        if (sa < 0 && (sa % p) != 0) q = q - 1;
        return 32'(q);
      end
      5'd8: return (b >= 32) ? 32'd0 : 32'(ua / p);
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode = op;
    data_a = a;
    data_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, prev;
    vecs.push_back('{"add_1_5",     5'd0, 32'd1,        32'd5,        32'd6});
    vecs.push_back('{"add_neg5_8",  5'd0, -32'sd5,      32'd8,        32'd3});
    vecs.push_back('{"sub_8_3",     5'd1, 32'd8,        32'd3,        32'd5});
    vecs.push_back('{"sub_0_3",     5'd1, 32'd0,        32'd3,        32'hFFFF_FFFD});
    vecs.push_back('{"add_wrap",    5'd0, 32'hFFFF_FFFF, 32'd1,       32'd0});
    vecs.push_back('{"mpy_8_7",     5'd2, 32'd8,        32'd7,        32'd56});
    vecs.push_back('{"mpy_wrap",    5'd2, 32'h1_0000,   32'h1_0000,   32'd0});
    vecs.push_back('{"and_18_7",    5'd3, 32'd18,       32'd7,        32'd2});
    vecs.push_back('{"or_8_1",      5'd4, 32'd8,        32'd1,        32'd9});
    vecs.push_back('{"xor_9_15",    5'd5, 32'd9,        32'd15,       32'd6});
    vecs.push_back('{"shl_7_3",     5'd6, 32'd7,        32'd3,        32'd56});
    vecs.push_back('{"shl_neg4_2",  5'd6, -32'sd4,      32'd2,        32'hFFFF_FFF0});
    vecs.push_back('{"shl_1_32",    5'd6, 32'd1,        32'd32,       32'd0});
    vecs.push_back('{"shl_by0",     5'd6, 32'hDEAD_BEEF, 32'd0,       32'hDEAD_BEEF});
    vecs.push_back('{"sra_34_2",    5'd7, 32'd34,       32'd2,        32'd8});
    vecs.push_back('{"sra_neg200",  5'd7, -32'sd200,    32'd2,        32'hFFFF_FFCE});
    vecs.push_back('{"sra_neg_255", 5'd7, -32'sd200,    32'd255,      32'hFFFF_FFFF});
    vecs.push_back('{"sra_34_255",  5'd7, 32'd34,       32'd255,      32'd0});
    vecs.push_back('{"sra_by0",     5'd7, 32'h8000_0001, 32'd0,       32'h8000_0001});
    vecs.push_back('{"sra_hi_b",    5'd7, 32'h8000_0000, 32'h1_0000,  32'hFFFF_FFFF});
    vecs.push_back('{"srl_34_2",    5'd8, 32'd34,       32'd2,        32'd8});
    vecs.push_back('{"srl_neg200",  5'd8, -32'sd200,    32'd2,        32'h3FFF_FFCE});
    vecs.push_back('{"srl_by32",    5'd8, 32'hFFFF_FFFF, 32'd32,      32'd0});
    vecs.push_back('{"srl_hi_b",    5'd8, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0});
    vecs.push_back('{"illegal_20",  5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0});
    vecs.push_back('{"illegal_9",   5'd9, 32'hFFFF_FFFF, 32'd1,       32'd0});
    vecs.push_back('{"illegal_31",  5'd31, 32'hFFFF_FFFF, 32'd1,      32'd0});

    opcode = 5'd0;
    data_a = 32'd1;
    data_b = 32'd5;
    #1;
    chk("reset_async_start", data_out, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held_clk", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_no_edge", data_out, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_first_result", data_out, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_cycle", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      chk(vecs[i].name, data_out, vecs[i].exp);
    end

    prev = data_out;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      opcode = 5'd0;
      data_a = 32'(i * 100);
      data_b = 32'(i + 1);
      #1;
      chk("latency_hold", data_out, prev);
      @(posedge clk);
      #1;
      prev = 32'(i * 100 + i + 1);
      chk("latency_update", data_out, prev);
    end

    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 9));
      if (op == 5'd9) op = 5'($urandom_range(9, 31));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 31));
        1: b = 32'($urandom_range(32, 40));
        default: b = $urandom;
      endcase
      drive(op, a, b);
      chk($sformatf("rand_op%0d", op), data_out, model(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
